mod_div: RTL and testbench

Sequential modular divider for FIPS 203 coefficients: computes (op1 · op2⁻¹) mod 3329 using Fermat inversion (op2^(Q−2)) by left-to-right square-and-multiply, then one final multiply by op1. It reuses a single mod_mul instance for every multiply and is the inverse-direction companion to mod_mul in the poly-arith datapath. It serves scaling and normalisation steps that need division by a coefficient.

---
 rtl/poly_arith_pkg.sv | 20 ++
 rtl/mod_mul.sv | 31 +++
 rtl/mod_div.sv | 167 ++++++++++++++++
 tb/tb_mod_div.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/poly_arith_pkg.sv
// poly_arith_pkg: shared types and constants for the FIPS 203 polynomial
// arithmetic datapath (modulus Q = 3329, 12-bit coefficients).
//   coeff_t  : one reduced coefficient, 0..Q-1
//   Q        : the Kyber/ML-KEM prime
//   INV_EXP  : Q-2, the Fermat inversion exponent used by mod_div
//   mul_mod  : behavioural a*b mod Q, used by mod_mul
package poly_arith_pkg;

  typedef logic [11:0] coeff_t;

  localparam coeff_t Q       = 12'd3329;
  localparam coeff_t INV_EXP = Q - 12'd2;   // 12'b1100_1111_1111

  function automatic coeff_t mul_mod(input coeff_t a, input coeff_t b);
    logic [23:0] prod;
    prod = {12'd0, a} * {12'd0, b};
    return coeff_t'(prod % 24'(Q));
  endfunction

endpackage

// File: rtl/mod_mul.sv
// mod_mul: single-cycle-latency modular multiplier, result = op1*op2 mod Q.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_i           operands valid this cycle
//   op1_i, op2_i      reduced operands (coeff_t)
//   result_o          reduced product, registered
//   valid_o           high the cycle after valid_i; cleared by reset so an
//                     in-flight product is dropped
module mod_mul
  import poly_arith_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   valid_i,
  input  coeff_t op1_i,
  input  coeff_t op2_i,
  output coeff_t result_o,
  output logic   valid_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) result_o <= mul_mod(op1_i, op2_i);
    end
  end

endmodule

// File: rtl/mod_div.sv
// mod_div: sequential modular divider, result = op1 * op2^-1 mod Q.
// The inverse is op2^(Q-2) by left-to-right square-and-multiply over the
// low 11 bits of INV_EXP (the MSB is consumed by loading acc = op2), then
// one final multiply by op1. A single mod_mul is shared for all 21 ops;
// each op takes an issue cycle and a capture cycle, 44 cycles per job.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   op1_i, op2_i      dividend / divisor, 0..Q-1
//   valid_i           accepted when valid_i & ready_o
//   ready_o           high only in IDLE
//   result_o          quotient, held until the next completion
//   valid_o           one-cycle pulse with a new result_o
//   div_by_zero_o     only with MOD_DIV_ZERO_CHK_EN defined: flags a job
//                     with op2 == 0, which then finishes in one cycle
// Optional feature macro: MOD_DIV_ZERO_CHK_EN
//
// state | meaning
// IDLE  | waiting for valid_i, ready_o high
// SQR   | acc <= acc*acc (issue, then capture)
// MUL   | acc <= acc*base_r, taken when the current exponent bit is 1
// DIV   | acc <= acc*dvd_r, the final multiply by the dividend
// DONE  | valid_o high for this cycle, then back to IDLE
module mod_div
  import poly_arith_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  coeff_t op1_i,
  input  coeff_t op2_i,
  input  logic   valid_i,
  output logic   ready_o,
  output coeff_t result_o,
  output logic   valid_o
`ifdef MOD_DIV_ZERO_CHK_EN
  ,
  output logic   div_by_zero_o
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_SQR, S_MUL, S_DIV, S_DONE} state_t;

  state_t     state;
  logic       issue;      // 1: issue sub-cycle, 0: capture sub-cycle
  logic [3:0] bit_idx;
  coeff_t     acc;
  coeff_t     base_r;
  coeff_t     dvd_r;

  logic       in_op;
  logic       mm_valid_i;
  logic       mm_valid_o;
  coeff_t     mm_op2;
  coeff_t     mm_result;

  assign in_op      = (state == S_SQR) || (state == S_MUL) || (state == S_DIV);
  assign mm_valid_i = in_op && issue;

  always_comb begin
    mm_op2 = acc;
    case (state)
      S_MUL:   mm_op2 = base_r;
      S_DIV:   mm_op2 = dvd_r;
      default: mm_op2 = acc;
    endcase
  end

  mod_mul u_mod_mul (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (mm_valid_i),
    .op1_i    (acc),
    .op2_i    (mm_op2),
    .result_o (mm_result),
    .valid_o  (mm_valid_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      issue    <= 1'b1;
      bit_idx  <= '0;
      acc      <= '0;
      base_r   <= '0;
      dvd_r    <= '0;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      result_o <= '0;
`ifdef MOD_DIV_ZERO_CHK_EN
      div_by_zero_o <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            dvd_r   <= op1_i;
            base_r  <= op2_i;
            acc     <= op2_i;
            bit_idx <= 4'd10;
            issue   <= 1'b1;
            ready_o <= 1'b0;
`ifdef MOD_DIV_ZERO_CHK_EN
            div_by_zero_o <= (op2_i == '0);
            if (op2_i == '0) begin
              result_o <= '0;
              valid_o  <= 1'b1;
              state    <= S_DONE;
            end else begin
              state <= S_SQR;
            end
`else
            state <= S_SQR;
`endif
          end
        end

        S_SQR, S_MUL, S_DIV: begin
          if (issue) begin
            issue <= 1'b0;
          end else begin
            issue <= 1'b1;
            acc   <= mm_result;
            case (state)
              S_SQR: begin
                if (INV_EXP[bit_idx])  state <= S_MUL;
                else if (bit_idx == 0) state <= S_DIV;
                else                   bit_idx <= bit_idx - 4'd1;
              end
              S_MUL: begin
                if (bit_idx == 0) begin
                  state <= S_DIV;
                end else begin
                  bit_idx <= bit_idx - 4'd1;
                  state   <= S_SQR;
                end
              end
              default: begin
                // DIV capture: publish directly so valid_o lands in DONE
                result_o <= mm_result;
                valid_o  <= 1'b1;
                state    <= S_DONE;
              end
            endcase
          end
        end

        S_DONE: begin
          state   <= S_IDLE;
          ready_o <= 1'b1;
        end

        default: begin
          state   <= S_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // every capture cycle relies on the multiplier's one-cycle latency
  always_ff @(posedge clk) begin
    if (!rst && in_op && !issue) assert (mm_valid_o);
  end
`endif

endmodule

// File: tb/tb_mod_div.sv
// tb_mod_div: self-checking bench for mod_div. Expected quotients come from
// a brute-force inverse search (x with op2*x mod Q == 1), independent of the
// exponentiation the design performs. Handles both builds of
// MOD_DIV_ZERO_CHK_EN.
module tb_mod_div;

  localparam int QM = 3329;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] op1_i;
  logic [11:0] op2_i;
  logic        valid_i;
  logic        ready_o;
  logic [11:0] result_o;
  logic        valid_o;
`ifdef MOD_DIV_ZERO_CHK_EN
  logic        div_by_zero_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  mod_div dut (
    .clk      (clk),
    .rst      (rst),
    .op1_i    (op1_i),
    .op2_i    (op2_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .result_o (result_o),
    .valid_o  (valid_o)
`ifdef MOD_DIV_ZERO_CHK_EN
    ,
    .div_by_zero_o (div_by_zero_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int ref_quot(input int a, input int b);
    if (b == 0) return 0;
    for (int x = 1; x < QM; x++)
      if ((b * x) % QM == 1) return (a * x) % QM;
    return -1;
  endfunction

  // Starts and ends on a falling edge; lat counts cycles after the accept edge.
  task automatic run_job(input int a, input int b, input string tag,
                         output int res, output int lat, output int dbz);
    int guard;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk({tag, "_ready_wait"}, 32'(ready_o), 1);
    op1_i   = 12'(a);
    op2_i   = 12'(b);
    valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, "_busy"}, 32'(ready_o), 0);
    end while (valid_o !== 1'b1 && lat < 100);
    if (valid_o !== 1'b1) chk({tag, "_timeout"}, 32'(valid_o), 1);
    res = int'(result_o);
`ifdef MOD_DIV_ZERO_CHK_EN
    dbz = int'(div_by_zero_o);
`else
    dbz = 0;
`endif
    @(negedge clk);
    chk({tag, "_pulse_len"}, 32'(valid_o), 0);
    chk({tag, "_ready_after"}, 32'(ready_o), 1);
  endtask

  int da[5] = '{1, 5, 3328, 1, 0};
  int db[5] = '{2, 3, 3328, 3328, 1234};
  int de[5] = '{1665, 2221, 1, 3328, 0};

  initial begin
    int res, lat, dbz, a, b, pulses;
    int p_cyc[2];
    int p_res[2];
    int ea, eb;

    rst = 1'b1; valid_i = 1'b0; op1_i = '0; op2_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready_o), 1);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_result", 32'(result_o), 0);
`ifdef MOD_DIV_ZERO_CHK_EN
    chk("rst_dbz", 32'(div_by_zero_o), 0);
`endif

    // directed quotients
    for (int i = 0; i < 5; i++) begin
      run_job(da[i], db[i], "dir", res, lat, dbz);
      chk("dir_result", 32'(res), 32'(de[i]));
      chk("dir_latency", 32'(lat), 43);
    end

    // back-to-back with valid_i held high; junk inputs while busy
    ea = 10; eb = 20;
    a = 1234; b = 77;
    pulses = 0;
    op1_i = 12'(ea); op2_i = 12'(eb); valid_i = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 100; n++) begin
      #1;
      if (n < 30) begin
        op1_i = 12'($urandom_range(0, QM - 1));
        op2_i = 12'($urandom_range(1, QM - 1));
      end else begin
        op1_i = 12'(a);
        op2_i = 12'(b);
      end
      if (n >= 45) valid_i = 1'b0;
      @(negedge clk);
      if (valid_o === 1'b1) begin
        if (pulses < 2) begin
          p_cyc[pulses] = n;
          p_res[pulses] = int'(result_o);
        end
        pulses++;
      end
      if (n == 44) chk("b2b_ready44", 32'(ready_o), 1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("b2b_pulses", 32'(pulses), 2);
    if (pulses >= 2) begin
      chk("b2b_cyc1", 32'(p_cyc[0]), 43);
      chk("b2b_res1", 32'(p_res[0]), 32'(ref_quot(ea, eb)));
      chk("b2b_cyc2", 32'(p_cyc[1]), 87);
      chk("b2b_res2", 32'(p_res[1]), 32'(ref_quot(a, b)));
    end

    // reset in the middle of a job
    op1_i = 12'd1234; op2_i = 12'd567; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready_o), 1);
    chk("abort_valid", 32'(valid_o), 0);
    pulses = 0;
    repeat (60) begin
      @(negedge clk);
      if (valid_o === 1'b1) pulses++;
    end
    chk("abort_no_valid", 32'(pulses), 0);
    run_job(1, 1, "post_abort", res, lat, dbz);
    chk("post_abort_result", 32'(res), 1);
    chk("post_abort_latency", 32'(lat), 43);

    // division by zero
    run_job(7, 0, "zero", res, lat, dbz);
    chk("zero_result", 32'(res), 0);
`ifdef MOD_DIV_ZERO_CHK_EN
    chk("zero_latency", 32'(lat), 1);
    chk("zero_flag", 32'(dbz), 1);
`else
    chk("zero_latency", 32'(lat), 43);
`endif
    run_job(9, 5, "after_zero", res, lat, dbz);
    chk("after_zero_result", 32'(res), 32'(ref_quot(9, 5)));
`ifdef MOD_DIV_ZERO_CHK_EN
    chk("after_zero_flag", 32'(dbz), 0);
`endif

    // random sweep of legal operands
    for (int i = 0; i < 250; i++) begin
      a = int'($urandom_range(0, QM - 1));
      b = int'($urandom_range(1, QM - 1));
      run_job(a, b, "rnd", res, lat, dbz);
      chk("rnd_result", 32'(res), 32'(ref_quot(a, b)));
      chk("rnd_identity", 32'((res * b) % QM), 32'(a));
      chk("rnd_latency", 32'(lat), 43);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
